registro_universal: RTL and testbench

- Synthesizable W-bit universal shift/rotate register. It is the device-under-test end of the CLK/ENB/MODO/D → Q/RCO interface driven by the team's register benches.
- Provides parallel load, logical shift left and right with a serial input, and rotate-left with a full-turn carry pulse.
- RCO allows registers to be cascaded or a bench to check words bit-serially.

---
 rtl/registro_universal.sv | 51 +++++
 tb/tb_registro_universal.sv | 119 +++++++++++
 2 files changed

// File: rtl/registro_universal.sv
// registro_universal: universal shift/rotate register with parallel load and full-turn carry pulse
// Ports: CLK clock, RESET sync active-high reset, ENB enable (0 = hold), MODO operation
// (11 load, 00 shift left, 01 shift right, 10 rotate left), D load data, S_IN serial in,
// Q registered contents, RCO registered carry (shifted-out bit or full-rotation pulse).
module registro_universal #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    input  logic             S_IN,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] r_q;
    logic             r_rco;
    logic [CW-1:0]    r_rot;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_rco_nxt;
    logic [CW-1:0]    w_rot_nxt;
    logic             w_wrap;
    // the edge that completes WIDTH enabled rotates brings Q back to its starting value
    assign w_wrap    = r_rot == CW'(WIDTH - 1);
    assign w_q_nxt   = MODO == 2'b11 ? D :
                       MODO == 2'b00 ? {r_q[WIDTH-2:0], S_IN} :
                       MODO == 2'b01 ? {S_IN, r_q[WIDTH-1:1]} :
                                       {r_q[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_rco_nxt = MODO == 2'b00 ? r_q[WIDTH-1] :
                       MODO == 2'b01 ? r_q[0] :
                       MODO == 2'b10 && w_wrap;
    // any enabled non-rotate edge restarts the rotation count
    assign w_rot_nxt = (MODO == 2'b10 && !w_wrap) ? r_rot + 1'b1 : '0;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q   <= '0;
            r_rco <= 1'b0;
            r_rot <= '0;
        end else if (!ENB) begin
            r_rco <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_rco <= w_rco_nxt;
            r_rot <= w_rot_nxt;
        end
    end
    assign Q   = r_q;
    assign RCO = r_rco;
endmodule

// File: tb/tb_registro_universal.sv
// tb_registro_universal: directed bench with per-cycle model comparison for registro_universal
module tb_registro_universal;
    localparam int W = 4;
    localparam int M = 1 << W;
    localparam int H = 1 << (W - 1);
    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         ENB = 1'b1;
    logic [1:0]   MODO = 2'b11;
    logic [W-1:0] D = '0;
    logic         S_IN = 1'b0;
    logic [W-1:0] Q;
    logic         RCO;
    int n_cmp = 0;
    int n_bad = 0;
    int m_q = 0;
    int m_rco = 0;
    int m_run = 0;
    bit m_valid = 1'b0;
    registro_universal #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO),
        .D(D), .S_IN(S_IN), .Q(Q), .RCO(RCO)
    );
    always #5 CLK = ~CLK;
    // model: Q as an integer, RCO from the bit leaving it; a full turn is every W-th
    // consecutive enabled rotate since the last reset or enabled non-rotate edge
    always @(posedge CLK) begin
        if (RESET) begin
            m_q <= 0; m_rco <= 0; m_run <= 0; m_valid <= 1'b1;
        end else if (!ENB) begin
            m_rco <= 0;
        end else if (MODO == 2'b11) begin
            m_q <= int'(D); m_rco <= 0; m_run <= 0;
        end else if (MODO == 2'b00) begin
            m_q <= (m_q * 2 + int'(S_IN)) % M; m_rco <= int'(m_q >= H); m_run <= 0;
        end else if (MODO == 2'b01) begin
            m_q <= m_q / 2 + int'(S_IN) * H; m_rco <= m_q % 2; m_run <= 0;
        end else begin
            m_q <= (m_q * 2) % M + m_q / H; m_run <= m_run + 1;
            m_rco <= int'((m_run + 1) % W == 0);
        end
    end
    always @(negedge CLK) begin
        if (m_valid) begin
            n_cmp++;
            if (int'(Q) != m_q || int'(RCO) != m_rco) begin
                n_bad++;
                $display("FAIL model t=%0t Q=%b RCO=%b expected Q=%0d RCO=%0d", $time, Q, RCO, m_q, m_rco);
            end
        end
    end
    task automatic st(input logic r, input logic e, input logic [1:0] m, input logic [W-1:0] d,
                      input logic s, input logic [W-1:0] eq, input logic erco, input string nm);
        @(negedge CLK);
        RESET = r; ENB = e; MODO = m; D = d; S_IN = s;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== eq || RCO !== erco) begin
            n_bad++;
            $display("FAIL %s Q=%b RCO=%b expected Q=%b RCO=%b", nm, Q, RCO, eq, erco);
        end
        n_cmp++;
        if (m_q != int'(eq) || m_rco != int'(erco)) begin
            n_bad++;
            $display("FAIL %s_model q=%0d rco=%0d expected Q=%b RCO=%b", nm, m_q, m_rco, eq, erco);
        end
    endtask
    initial begin
        st(1, 1, 2'b11, 4'b1010, 0, 4'b0000, 0, "rst1");
        st(1, 1, 2'b11, 4'b1010, 0, 4'b0000, 0, "rst2");
        for (int i = 0; i < 3; i++) st(0, 0, 2'b11, 4'b1010, 0, 4'b0000, 0, "hold0");
        st(0, 1, 2'b11, 4'b1001, 0, 4'b1001, 0, "load1001");
        st(0, 1, 2'b00, 4'b0000, 1, 4'b0011, 1, "shl1");
        st(0, 1, 2'b00, 4'b1111, 1, 4'b0111, 0, "shl2");
        st(0, 1, 2'b00, 4'b0000, 1, 4'b1111, 0, "shl3");
        st(0, 1, 2'b00, 4'b0000, 1, 4'b1111, 1, "shl4");
        st(0, 1, 2'b11, 4'b0110, 1, 4'b0110, 0, "load0110");
        st(0, 1, 2'b01, 4'b1111, 0, 4'b0011, 0, "shr1");
        st(0, 1, 2'b01, 4'b0000, 0, 4'b0001, 1, "shr2");
        st(0, 1, 2'b01, 4'b0000, 0, 4'b0000, 1, "shr3");
        st(0, 1, 2'b01, 4'b0000, 0, 4'b0000, 0, "shr4");
        st(0, 1, 2'b01, 4'b0000, 1, 4'b1000, 0, "shr_sin1");
        st(0, 1, 2'b11, 4'b1000, 0, 4'b1000, 0, "load1000");
        st(0, 1, 2'b10, 4'b1111, 1, 4'b0001, 0, "rot1");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0010, 0, "rot2");
        st(0, 1, 2'b10, 4'b0000, 1, 4'b0100, 0, "rot3");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b1000, 1, "rot4");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0001, 0, "rot5");
        st(0, 1, 2'b11, 4'b0001, 0, 4'b0001, 0, "load0001a");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0010, 0, "prot1");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0100, 0, "prot2");
        for (int i = 0; i < 3; i++) st(0, 0, 2'b10, 4'b1111, 1, 4'b0100, 0, "phold");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b1000, 0, "prot3");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0001, 1, "prot4");
        st(0, 1, 2'b11, 4'b0001, 0, 4'b0001, 0, "load0001b");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0010, 0, "irot1");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0100, 0, "irot2");
        st(0, 1, 2'b00, 4'b0000, 0, 4'b1000, 0, "ishl");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0001, 0, "irot3");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0010, 0, "irot4");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0100, 0, "irot5");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b1000, 1, "irot6");
        st(0, 1, 2'b11, 4'b1100, 0, 4'b1100, 0, "load1100a");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b1001, 0, "rrot1");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0011, 0, "rrot2");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0110, 0, "rrot3");
        st(1, 1, 2'b10, 4'b0000, 0, 4'b0000, 0, "midrst");
        st(0, 1, 2'b11, 4'b1100, 0, 4'b1100, 0, "load1100b");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b1001, 0, "arot1");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0011, 0, "arot2");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b0110, 0, "arot3");
        st(0, 1, 2'b10, 4'b0000, 0, 4'b1100, 1, "arot4");
        st(0, 0, 2'b10, 4'b0000, 0, 4'b1100, 0, "hold_clr_rco");
        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
